// File: rtl/cpu_fetch_decode_pkg.sv
// Shared types for the 6502 fetch/pre-decode front end: addressing modes, fetch states,
// the decoded-instruction queue entry and the opcode classifier.
// Pure types and a combinational function only; no state.
package cpu_fd_pkg;

    // Width of the pc field carried in a queue entry; the top supports ADDR_W up to this.
    localparam int PC_W = 16;

    typedef enum logic [2:0] {
        AM_IMM  = 3'd0,
        AM_ZP   = 3'd1,
        AM_ZPX  = 3'd2,
        AM_ABS  = 3'd3,
        AM_ABSX = 3'd4,
        AM_ABSY = 3'd5,
        AM_IMP  = 3'd6,
        AM_REL  = 3'd7
    } addr_mode_t;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_OPC   = 2'd1,
        S_OP1   = 2'd2,
        S_OP2   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [7:0]      opcode;
        logic [15:0]     operand;
        logic [PC_W-1:0] pc;
        logic [1:0]      len;
        addr_mode_t      mode;
        logic            illegal;
    } inst_entry_t;

    typedef struct packed {
        logic [1:0] len;
        addr_mode_t mode;
        logic       illegal;
    } predec_t;

    // Classify an opcode. Anything outside the supported set is a 1-byte implied illegal.
    function automatic predec_t predecode(input logic [7:0] opcode);
        predec_t pd;
        pd.len     = 2'd1;
        pd.mode    = AM_IMP;
        pd.illegal = 1'b1;
        case (opcode)
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9: begin
                pd.len = 2'd2; pd.mode = AM_IMM; pd.illegal = 1'b0;
            end
            8'hA5, 8'h85: begin
                pd.len = 2'd2; pd.mode = AM_ZP; pd.illegal = 1'b0;
            end
            8'hB5, 8'h95: begin
                pd.len = 2'd2; pd.mode = AM_ZPX; pd.illegal = 1'b0;
            end
            8'hAD, 8'h8D, 8'h4C, 8'h20: begin
                pd.len = 2'd3; pd.mode = AM_ABS; pd.illegal = 1'b0;
            end
            8'hBD, 8'h9D: begin
                pd.len = 2'd3; pd.mode = AM_ABSX; pd.illegal = 1'b0;
            end
            8'hB9, 8'h99: begin
                pd.len = 2'd3; pd.mode = AM_ABSY; pd.illegal = 1'b0;
            end
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: begin
                pd.len = 2'd2; pd.mode = AM_REL; pd.illegal = 1'b0;
            end
            8'hAA, 8'hA8, 8'h8A, 8'h98, 8'h0A, 8'h4A, 8'h60, 8'h48,
            8'h68, 8'h38, 8'h18, 8'hEA, 8'hE8, 8'hC8, 8'hCA, 8'h88: begin
                pd.len = 2'd1; pd.mode = AM_IMP; pd.illegal = 1'b0;
            end
            default: begin
                pd.len = 2'd1; pd.mode = AM_IMP; pd.illegal = 1'b1;
            end
        endcase
        return pd;
    endfunction

endpackage

// File: rtl/cpu_fetch_decode_if.sv
// Bundle of the fetch front end's memory port, redirect input and decoded-instruction output.
// No logic; master is the fetch unit, slave is the memory/execute side.
// Flow control: mem_req/mem_ready for bytes, inst_valid/inst_ready for decoded entries.
interface cpu_fetch_decode_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [7:0]        mem_rdata;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    logic              inst_valid;
    logic              inst_ready;
    logic [7:0]        inst_opcode;
    logic [15:0]       inst_operand;
    logic [ADDR_W-1:0] inst_pc;
    logic [1:0]        inst_len;
    logic [2:0]        inst_addr_mode;
    logic              inst_illegal;
    logic [15:0]       fetch_count;

    modport master (
        output mem_req, mem_addr,
        input  mem_ready, mem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_opcode, inst_operand, inst_pc, inst_len, inst_addr_mode, inst_illegal,
        output fetch_count
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ready, mem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_opcode, inst_operand, inst_pc, inst_len, inst_addr_mode, inst_illegal,
        input  fetch_count
    );

endinterface

// File: rtl/cpu_fetch_decode_queue.sv
// Small synchronous FIFO of decoded-instruction entries with flush.
// Latency: a pushed entry appears at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module cpu_inst_queue
    import cpu_fd_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  inst_entry_t       i_push_dat,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output inst_entry_t       o_head_dat
);

    inst_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Head is forced to zero when empty so downstream never sees stale fields.
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush drops every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy masks it.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/cpu_fetch_decode.sv
// 6502 fetch/pre-decode: reads opcode plus 0-2 operand bytes, classifies, queues the bundle.
// Latency: one accepted byte per cycle; entry valid the cycle after its last byte is accepted.
// Backpressure: no new opcode fetch while the queue is full; mem_req/mem_addr held through stalls.
module cpu_fetch_decode
    import cpu_fd_pkg::*;
#(
    parameter  int              ADDR_W      = 16,
    parameter  logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(16'h0200),
    parameter  int              QUEUE_DEPTH = 2,
    localparam int              CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_fetch_decode_if.master bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [7:0]        r_opcode;
    logic [7:0]        r_lo;
    logic [15:0]       r_fetch_count;

    logic              w_mem_req;
    logic              w_adv;
    logic              w_latch_opc;
    logic              w_latch_lo;
    logic              w_push;
    inst_entry_t       w_push_dat;
    predec_t           w_pd_new;
    predec_t           w_pd_held;

    logic              w_q_full;
    logic              w_q_empty;
    logic [CNT_W-1:0]  w_q_count;
    logic              w_pop;
    inst_entry_t       w_head;

    // The opcode byte is classified as it arrives; later bytes use the latched opcode.
    assign w_pd_new  = predecode(bus.mem_rdata);
    assign w_pd_held = predecode(r_opcode);

    // Next state, memory request and push decision; a redirect cancels any progress this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_adv       = 1'b0;
        w_latch_opc = 1'b0;
        w_latch_lo  = 1'b0;
        w_push      = 1'b0;
        w_push_dat  = '0;
        case (r_state)
            S_RESET: begin
                w_state_nxt = S_OPC;
            end
            S_OPC: begin
                // Full can only clear while waiting here, so a raised request stays raised.
                w_mem_req = !w_q_full;
                if (!w_q_full && bus.mem_ready) begin
                    w_adv       = 1'b1;
                    w_latch_opc = 1'b1;
                    if (w_pd_new.len == 2'd1) begin
                        w_push             = 1'b1;
                        w_push_dat.opcode  = bus.mem_rdata;
                        w_push_dat.operand = 16'h0000;
                        w_push_dat.pc      = PC_W'(r_pc);
                        w_push_dat.len     = w_pd_new.len;
                        w_push_dat.mode    = w_pd_new.mode;
                        w_push_dat.illegal = w_pd_new.illegal;
                    end else begin
                        w_state_nxt = S_OP1;
                    end
                end
            end
            S_OP1: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_adv      = 1'b1;
                    w_latch_lo = 1'b1;
                    if (w_pd_held.len == 2'd2) begin
                        w_push             = 1'b1;
                        w_push_dat.opcode  = r_opcode;
                        w_push_dat.operand = {8'h00, bus.mem_rdata};
                        w_push_dat.pc      = PC_W'(r_inst_pc);
                        w_push_dat.len     = w_pd_held.len;
                        w_push_dat.mode    = w_pd_held.mode;
                        w_push_dat.illegal = w_pd_held.illegal;
                        w_state_nxt        = S_OPC;
                    end else begin
                        w_state_nxt = S_OP2;
                    end
                end
            end
            S_OP2: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_adv              = 1'b1;
                    w_push             = 1'b1;
                    w_push_dat.opcode  = r_opcode;
                    w_push_dat.operand = {bus.mem_rdata, r_lo};
                    w_push_dat.pc      = PC_W'(r_inst_pc);
                    w_push_dat.len     = w_pd_held.len;
                    w_push_dat.mode    = w_pd_held.mode;
                    w_push_dat.illegal = w_pd_held.illegal;
                    w_state_nxt        = S_OPC;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
        if (bus.redirect_valid) begin
            w_state_nxt = S_OPC;
            w_adv       = 1'b0;
            w_latch_opc = 1'b0;
            w_latch_lo  = 1'b0;
            w_push      = 1'b0;
        end
    end

    // Fetch state, program counter, partial-instruction holding registers and push counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_inst_pc     <= '0;
            r_opcode      <= '0;
            r_lo          <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.redirect_valid) r_pc <= bus.redirect_pc;
            else if (w_adv)         r_pc <= r_pc + 1'b1;
            if (w_latch_opc) begin
                r_opcode  <= bus.mem_rdata;
                r_inst_pc <= r_pc;
            end
            if (w_latch_lo) r_lo <= bus.mem_rdata;
            if (w_push)     r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign w_pop = !w_q_empty && bus.inst_ready;

    cpu_inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (bus.redirect_valid),
        .o_full     (w_q_full),
        .o_empty    (w_q_empty),
        .o_count    (w_q_count),
        .o_head_dat (w_head)
    );

    // A fetch only starts with a free slot and nothing else pushes, so a push never meets a full queue.
    assert property (@(posedge clk) disable iff (!rst_n) w_push |-> (w_q_count < CNT_W'(QUEUE_DEPTH)));

    assign bus.mem_req        = w_mem_req;
    assign bus.mem_addr       = r_pc;
    assign bus.inst_valid     = !w_q_empty;
    assign bus.inst_opcode    = w_head.opcode;
    assign bus.inst_operand   = w_head.operand;
    assign bus.inst_pc        = ADDR_W'(w_head.pc);
    assign bus.inst_len       = w_head.len;
    assign bus.inst_addr_mode = w_head.mode;
    assign bus.inst_illegal   = w_head.illegal;
    assign bus.fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Directed bench for cpu_fetch_decode: opcode table plus hand-written stall/full/redirect/reset sequences.
// A second instance starts at 0xFFFF to cover pc wrap.
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_fetch_decode;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_fetch_decode_if #(.ADDR_W(16)) bus ();
    cpu_fetch_decode_if #(.ADDR_W(16)) bus_w ();

    cpu_fetch_decode #(.ADDR_W(16), .RESET_PC(16'h0200), .QUEUE_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cpu_fetch_decode #(.ADDR_W(16), .RESET_PC(16'hFFFF), .QUEUE_DEPTH(2)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    logic [7:0] mem [0:1023];
    assign bus.mem_rdata   = mem[bus.mem_addr[9:0]];
    assign bus_w.mem_rdata = (bus_w.mem_addr == 16'hFFFF) ? 8'hA9 :
                             (bus_w.mem_addr == 16'h0000) ? 8'h07 : 8'hEA;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 40 && !bus.inst_valid; c++) @(negedge clk);
        check({name, "_valid"}, 32'(bus.inst_valid), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [15:0] operand;
        logic [1:0]  len;
        logic [2:0]  mode;
        logic        illegal;
    } vec_t;

    vec_t vecs[11];
    logic saw_valid;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'hA9, 8'h42, 8'h00, 16'h0042, 2'd2, 3'd0, 1'b0};
        vecs[1]  = '{8'hB5, 8'h10, 8'h00, 16'h0010, 2'd2, 3'd2, 1'b0};
        vecs[2]  = '{8'hBD, 8'h00, 8'h80, 16'h8000, 2'd3, 3'd4, 1'b0};
        vecs[3]  = '{8'h99, 8'hFF, 8'h01, 16'h01FF, 2'd3, 3'd5, 1'b0};
        vecs[4]  = '{8'hD0, 8'hFE, 8'h00, 16'h00FE, 2'd2, 3'd7, 1'b0};
        vecs[5]  = '{8'h60, 8'h55, 8'h55, 16'h0000, 2'd1, 3'd6, 1'b0};
        vecs[6]  = '{8'h85, 8'h44, 8'h00, 16'h0044, 2'd2, 3'd1, 1'b0};
        vecs[7]  = '{8'h20, 8'hCD, 8'hAB, 16'hABCD, 2'd3, 3'd3, 1'b0};
        vecs[8]  = '{8'h02, 8'h55, 8'h55, 16'h0000, 2'd1, 3'd6, 1'b1};
        vecs[9]  = '{8'hFF, 8'h55, 8'h55, 16'h0000, 2'd1, 3'd6, 1'b1};
        vecs[10] = '{8'h4C, 8'h00, 8'h03, 16'h0300, 2'd3, 3'd3, 1'b0};

        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.inst_ready = 1'b0;
        bus_w.mem_ready = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc = 16'h0000;
        bus_w.inst_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEA;

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_fetch_count", 32'(bus.fetch_count), 32'd0);
        check("rst_opcode", 32'(bus.inst_opcode), 32'd0);
        check("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0200);

        // A9 42: address sequence and first entry.
        mem[10'h200] = 8'hA9;
        mem[10'h201] = 8'h42;
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_req_addr0", 32'({bus.mem_req, bus.mem_addr}), 32'h0001_0200);
        @(negedge clk);
        check("t1_req_addr1", 32'({bus.mem_req, bus.mem_addr}), 32'h0001_0201);
        @(negedge clk);
        check("t1_valid", 32'(bus.inst_valid), 32'd1);
        check("t1_opcode", 32'(bus.inst_opcode), 32'hA9);
        check("t1_operand", 32'(bus.inst_operand), 32'h0042);
        check("t1_len", 32'(bus.inst_len), 32'd2);
        check("t1_mode", 32'(bus.inst_addr_mode), 32'd0);
        check("t1_pc", 32'(bus.inst_pc), 32'h0200);

        // Wrap instance: A9 at FFFF, operand at 0000, then EA at 0001 fills the queue.
        repeat (6) @(negedge clk);
        check("wrap_pc", 32'(bus_w.inst_pc), 32'hFFFF);
        check("wrap_opcode", 32'(bus_w.inst_opcode), 32'hA9);
        check("wrap_operand", 32'(bus_w.inst_operand), 32'h0007);
        check("wrap_len", 32'(bus_w.inst_len), 32'd2);
        check("wrap_count", 32'(bus_w.fetch_count), 32'd2);
        check("wrap_req_addr", 32'({bus_w.mem_req, bus_w.mem_addr}), 32'h0000_0002);

        // Opcode table.
        for (int i = 0; i < 11; i++) begin
            mem[10'h200] = vecs[i].b0;
            mem[10'h201] = vecs[i].b1;
            mem[10'h202] = vecs[i].b2;
            bus.mem_ready = 1'b1;
            bus.inst_ready = 1'b0;
            do_reset();
            wait_valid($sformatf("v%0d", i));
            check($sformatf("v%0d_opcode", i), 32'(bus.inst_opcode), 32'(vecs[i].b0));
            check($sformatf("v%0d_operand", i), 32'(bus.inst_operand), 32'(vecs[i].operand));
            check($sformatf("v%0d_len", i), 32'(bus.inst_len), 32'(vecs[i].len));
            check($sformatf("v%0d_mode", i), 32'(bus.inst_addr_mode), 32'(vecs[i].mode));
            check($sformatf("v%0d_illegal", i), 32'(bus.inst_illegal), 32'(vecs[i].illegal));
            check($sformatf("v%0d_pc", i), 32'(bus.inst_pc), 32'h0200);
        end

        // AD 34 12 with three stall cycles before each byte.
        mem[10'h200] = 8'hAD;
        mem[10'h201] = 8'h34;
        mem[10'h202] = 8'h12;
        bus.mem_ready = 1'b0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("stall_b%0d_c%0d", k, c), 32'({bus.mem_req, bus.mem_addr}),
                      32'h0001_0200 + 32'(k));
                @(negedge clk);
            end
            check($sformatf("stall_b%0d_xfer", k), 32'({bus.mem_req, bus.mem_addr}),
                  32'h0001_0200 + 32'(k));
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
        end
        check("stall_valid", 32'(bus.inst_valid), 32'd1);
        check("stall_operand", 32'(bus.inst_operand), 32'h1234);
        check("stall_len", 32'(bus.inst_len), 32'd3);
        check("stall_mode", 32'(bus.inst_addr_mode), 32'd3);
        check("stall_count", 32'(bus.fetch_count), 32'd1);

        // EA stream against a stalled consumer: queue fills, fetch stops, resumes on pop.
        for (int i = 10'h200; i < 10'h210; i++) mem[i] = 8'hEA;
        bus.mem_ready = 1'b1;
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        check("full_req_addr", 32'({bus.mem_req, bus.mem_addr}), 32'h0000_0202);
        check("full_count", 32'(bus.fetch_count), 32'd2);
        check("full_head_pc", 32'(bus.inst_pc), 32'h0200);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check("pop1_head_pc", 32'(bus.inst_pc), 32'h0201);
        check("pop1_req_addr", 32'({bus.mem_req, bus.mem_addr}), 32'h0001_0202);
        @(negedge clk);
        check("resume_count", 32'(bus.fetch_count), 32'd3);
        check("resume_head_pc", 32'(bus.inst_pc), 32'h0201);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check("pop2_head_pc", 32'(bus.inst_pc), 32'h0202);

        // Redirect during an operand stall, with a byte offered on the same edge.
        mem[10'h200] = 8'hAD;
        mem[10'h201] = 8'h34;
        mem[10'h202] = 8'h12;
        mem[10'h300] = 8'hEA;
        bus.mem_ready = 1'b1;
        do_reset();
        saw_valid = 1'b0;
        @(negedge clk);
        check("redir_addr0", 32'(bus.mem_addr), 32'h0200);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        saw_valid |= bus.inst_valid;
        @(negedge clk);
        check("redir_stall_addr", 32'({bus.mem_req, bus.mem_addr}), 32'h0001_0201);
        saw_valid |= bus.inst_valid;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0300;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.mem_ready = 1'b0;
        check("redir_valid", 32'(bus.inst_valid), 32'd0);
        check("redir_req_addr", 32'({bus.mem_req, bus.mem_addr}), 32'h0001_0300);
        check("redir_count", 32'(bus.fetch_count), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            saw_valid |= bus.inst_valid;
        end
        check("redir_no_partial", 32'(saw_valid), 32'd0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("redir_new_opcode", 32'(bus.inst_opcode), 32'hEA);
        check("redir_new_pc", 32'(bus.inst_pc), 32'h0300);
        check("redir_new_count", 32'(bus.fetch_count), 32'd1);

        // Illegal 02, then reset asserted in the middle of the following 8D.
        mem[10'h200] = 8'h02;
        mem[10'h201] = 8'h8D;
        mem[10'h202] = 8'h00;
        mem[10'h203] = 8'h03;
        bus.mem_ready = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("ill_opcode", 32'(bus.inst_opcode), 32'h02);
        check("ill_flag", 32'(bus.inst_illegal), 32'd1);
        check("ill_len_mode", 32'({bus.inst_len, bus.inst_addr_mode}), 32'({2'd1, 3'd6}));
        @(negedge clk);
        check("mid_req_addr", 32'({bus.mem_req, bus.mem_addr}), 32'h0001_0202);
        check("mid_count", 32'(bus.fetch_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.inst_valid), 32'd0);
        check("async_req", 32'(bus.mem_req), 32'd0);
        check("async_count", 32'(bus.fetch_count), 32'd0);
        check("async_addr", 32'(bus.mem_addr), 32'h0200);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_decode.md
Name: cpu_fetch_decode

Overview:
- Multi-cycle instruction fetch and pre-decode front end for the 6502 core.
- Fetches the opcode and 0-2 operand bytes over a byte-wide memory port with a ready handshake, and classifies the opcode (length, addressing mode, illegal).
- Pushes a complete decoded-instruction bundle into a small queue, which the execute stage (control decoder plus datapath) drains via valid/ready.
- Supports redirect/flush from execute on taken branches, JMP, JSR and RTS.

Parameters:
ADDR_W, 16, program-counter and memory address width.
RESET_PC, 16'h0200, fetch start address after reset (width ADDR_W).
QUEUE_DEPTH, 2, decoded-instruction queue entries; power of two, >= 1.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset.
mem_req  out  1  byte read request.
mem_addr  out  ADDR_W  read address.
mem_ready  in  1  read data valid this cycle; a transfer occurs when mem_req && mem_ready.
mem_rdata  in  8  read data.
redirect_valid  in  1  flush and refetch.
redirect_pc  in  ADDR_W  new fetch address.
inst_valid  out  1  queue head valid.
inst_ready  in  1  execute accepts head.
inst_opcode  out  8  opcode byte.
inst_operand  out  16  assembled operand.
inst_pc  out  ADDR_W  address of the opcode byte.
inst_len  out  2  instruction length, 1..3.
inst_addr_mode  out  3  addressing mode code.
inst_illegal  out  1  opcode is not in the supported set.
fetch_count  out  16  instructions pushed, wraps at 2^16.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state=S_RESET, pc=RESET_PC, queue empty, mem_req=0, inst_valid=0, fetch_count=0. All inst_* fields read 0 while the queue is empty.
- S_RESET: mem_req=0; moves to S_OPC on the next edge.
- S_OPC: mem_req=1 only when the queue is not full; mem_addr=pc.
  - On transfer: latch opcode and inst_pc, pc<=pc+1.
  - len=1: push the entry on the same edge and stay in S_OPC.
  - Otherwise go to S_OP1.
- S_OP1: mem_req=1; mem_addr=pc.
  - On transfer: latch the low byte, pc<=pc+1.
  - len=2: push and go to S_OPC. len=3: go to S_OP2.
- S_OP2: mem_req=1.
  - On transfer: latch the high byte, pc<=pc+1, push, go to S_OPC.
- Handshake rule: once mem_req is high, mem_req and mem_addr stay stable until the transfer completes (any number of stall cycles) or a redirect occurs.
- Full queue: fetch of a new instruction begins only when the queue is not full. Only the fetcher pushes, so a push can never find the queue full.
- pc arithmetic is modulo 2^ADDR_W: 0xFFFF+1 = 0x0000.
- Operand assembly:
  - len 3: {hi, lo}.
  - len 2: {8'h00, lo}.
  - len 1: 16'h0000.
- Addressing mode codes: IMM=0, ZP=1, ZPX=2, ABS=3, ABSX=4, ABSY=5, IMP=6, REL=7.
- Supported opcode set, with modes:
  - Immediate: A9 A2 A0 69 E9 29 09 49 C9.
  - Zero page: A5 85 (ZP); B5 95 (ZPX).
  - Absolute: AD 8D 4C 20 (ABS); BD 9D (ABSX); B9 99 (ABSY).
  - Relative: 10 30 50 70 90 B0 D0 F0 (REL).
  - Implied: AA A8 8A 98 0A 4A 60 48 68 38 18 EA E8 C8 CA 88 (IMP).
  - Any other opcode: len=1, IMP, inst_illegal=1.
- Queue output timing:
  - Queue output is registered; a pushed entry is visible on inst_valid the cycle after the push edge.
  - Pop occurs on inst_valid && inst_ready.
  - Push and pop on the same edge leave the count unchanged.
- Redirect: redirect_valid is sampled at the clock edge and has priority over push, pop and transfer. Effects on that edge:
  - queue emptied;
  - pc<=redirect_pc;
  - state<=S_OPC;
  - any byte transferred in that cycle is discarded;
  - fetch_count is not incremented.
- fetch_count increments on every push.
- Asserting rst_n low mid-fetch immediately forces all reset values.

Decomposition:
- Package cpu_fd_pkg holds:
  - the addr_mode enum;
  - the fetch-state enum (S_RESET, S_OPC, S_OP1, S_OP2);
  - the packed struct inst_entry_t {opcode, operand, pc, len, mode, illegal};
  - the pure function predecode(opcode) returning len, mode and illegal.
- Sub-module cpu_inst_queue: a parametrised synchronous FIFO of inst_entry_t with push, pop, flush, full, empty and count.

Test Plan:
- Reset; memory holds A9 42 at 0x0200 -> mem_addr is 0x0200 then 0x0201. Then inst_valid with opcode A9, operand 0x0042, len 2, mode IMM, pc 0x0200.
- AD 34 12 at 0x0200 with mem_ready low for 3 cycles before each byte -> mem_addr is held stable during each stall. Result: operand 0x1234, len 3, mode ABS; fetch_count=1.
- Stream of EA bytes with inst_ready=0 -> after 2 pushes, mem_req=0 and pc=0x0202. Raise inst_ready -> entries pop with pc 0x0200 and 0x0201, then fetch resumes at 0x0202.
- Fetch AD; during its operand stall, pulse redirect_valid with redirect_pc 0x0300 -> queue empty next cycle, next mem_addr=0x0300, no partial entry ever valid.
- RESET_PC=16'hFFFF; A9 at FFFF and 07 at 0000 -> operand fetched from 0x0000. Result: inst_pc 0xFFFF, operand 0x0007.
- Opcode 02 -> len 1, mode IMP, inst_illegal=1. Then assert rst_n low mid-fetch of a following 8D -> inst_valid=0, mem_req=0, fetch_count=0 immediately.
